seg7_scan_drv: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display; the next generation of the single-digit hex decoder. Latches a packed hex word plus per-digit decimal points on a load strobe, scans one digit at a time at a programmable rate, and drives active-low segment and digit-select lines. Sits between the clock/counter datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_dec_core.sv | 24 ++
 rtl/seg7_scan_drv.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_drv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Holds the segment type, the all-off pattern, the hex-to-segment table (active-low,
// [6:0] = g..a, [7] = dp, dp off) and the maximum supported digit count.
package seg7_pkg;

  localparam int unsigned MaxDigits = 8;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  // Index 15 is leftmost: F, E, d, C, b, A, 9 .. 0.
  localparam seg_t [15:0] SegTable = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // dp = 1 means the decimal point is lit, which drives bit 7 low.
  function automatic seg_t hex_to_seg(input logic [3:0] nib, input logic dp);
    seg_t s;
    s = SegTable[nib];
    return {~dp, s[6:0]};
  endfunction

endpackage

// File: rtl/seg7_dec_core.sv
// Combinational nibble + decimal point to active-low segment lookup.
// Ports:
//   nibble_i  hex digit to display
//   dp_i      decimal point request, 1 = lit
//   blank_i   force all segments off
//   n_hex_o   active-low segments, [6:0] = g..a, [7] = dp
module seg7_dec_core
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output seg_t       n_hex_o
);

  always_comb begin
    if (blank_i) begin
      n_hex_o = SEG_OFF;
    end else begin
      n_hex_o = hex_to_seg(nibble_i, dp_i);
    end
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
// Latches DIN/DP into a shadow register on LOAD, scans one digit per PRESCALE cycles with
// BLANK all-off cycles at the start of each slot, and drives registered active-low outputs.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
// Ports:
//   CLK    system clock, rising edge
//   nRST   asynchronous active-low reset
//   LOAD   one-cycle strobe capturing DIN/DP
//   DIN    packed hex value, nibble k -> digit k
//   DP     per-digit decimal point, 1 = lit
//   EN     display enable, 0 blanks outputs (scan keeps running)
//   nHEX   active-low segments, [6:0] = g..a, [7] = dp
//   nDSEL  active-low digit select, at most one bit low
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DIN,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  EN,
  output logic [7:0]            nHEX,
  output logic [DIGITS-1:0]     nDSEL
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(DIGITS - 1);

  logic [4*DIGITS-1:0] din_q, din_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  seg_t                nhex_q, nhex_d;
  logic [DIGITS-1:0]   ndsel_q, ndsel_d;

  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       slot_blank;
  logic       lzb_blank;
  seg_t       dec_seg;

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] lzb_q, lzb_d;
  logic              seen;

  // Flags are computed from the value being captured so they always match the shadow.
  always_comb begin
    lzb_d = lzb_q;
    seen  = 1'b0;
    if (LOAD) begin
      lzb_d = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        seen     = seen | (DIN[4*k +: 4] != 4'h0) | DP[k];
        lzb_d[k] = ~seen;
      end
    end
  end

  assign lzb_blank = lzb_q[idx_q];
`else
  assign lzb_blank = 1'b0;
`endif

  always_comb begin
    din_d = din_q;
    dp_d  = dp_q;
    if (LOAD) begin
      din_d = DIN;
      dp_d  = DP;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  assign cur_nib    = din_q[{idx_q, 2'b00} +: 4];
  assign cur_dp     = dp_q[idx_q];
  assign slot_blank = (cnt_q < CntBlank) | ~EN;

  seg7_dec_core u_dec (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .blank_i  (slot_blank | lzb_blank),
    .n_hex_o  (dec_seg)
  );

  // A leading-zero-blanked digit keeps its select low; only the segments go dark.
  always_comb begin
    nhex_d  = dec_seg;
    ndsel_d = '1;
    if (!slot_blank) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IdxW'(k)) begin
          ndsel_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      din_q   <= '0;
      dp_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      nhex_q  <= SEG_OFF;
      ndsel_q <= '1;
`ifdef SEG7_LZB_EN
      lzb_q   <= '0;
`endif
    end else begin
      din_q   <= din_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nhex_q  <= nhex_d;
      ndsel_q <= ndsel_d;
`ifdef SEG7_LZB_EN
      lzb_q   <= lzb_d;
`endif
    end
  end

  assign nHEX  = nhex_q;
  assign nDSEL = ndsel_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
module tb_seg7_scan_drv;

  localparam int unsigned Digits   = 4;
  localparam int unsigned Prescale = 4;
  localparam int unsigned Blank    = 1;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        load;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dp;
  logic [7:0]  n_hex;
  logic [3:0]  n_dsel;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] exp_seg [4];

  always #5 clk = ~clk;

  seg7_scan_drv #(
    .DIGITS   (Digits),
    .PRESCALE (Prescale),
    .BLANK    (Blank)
  ) dut (
    .CLK   (clk),
    .nRST  (n_rst),
    .LOAD  (load),
    .DIN   (din),
    .DP    (dp),
    .EN    (en),
    .nHEX  (n_hex),
    .nDSEL (n_dsel)
  );

  // Advance one edge; cyc counts edges since the last reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] h, input logic [3:0] d);
    checks++;
    assert (n_hex === h && n_dsel === d)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d nHEX=%h want %h nDSEL=%b want %b", tag, cyc, n_hex, h, n_dsel, d);
    end
  endtask

  // Output after edge n reflects counter/index state after edge n-1.
  task automatic chk_model(input string tag);
    int ph;
    int dg;
    logic [3:0] sel;
    ph  = (cyc - 1) % Prescale;
    dg  = ((cyc - 1) / Prescale) % Digits;
    sel = 4'b1111;
    sel[dg] = 1'b0;
    if (ph < Blank) chk(tag, 8'hFF, 4'b1111);
    else chk(tag, exp_seg[dg], sel);
    checks++;
    assert ($countones(~n_dsel) <= 1)
    else begin
      failures++;
      $error("FAIL %s_onehot cyc=%0d nDSEL=%b want at most one low", tag, cyc, n_dsel);
    end
  endtask

  task automatic set_zero_table();
`ifdef SEG7_LZB_EN
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_seg = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
  endtask

  initial begin
    n_rst = 1'b0;
    load  = 1'b0;
    en    = 1'b1;
    din   = 16'h0;
    dp    = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 8'hFF, 4'b1111);
    @(negedge clk);
    n_rst = 1'b1;
    cyc   = 0;
    set_zero_table();
    step(); chk_model("first_blank");
    step(); chk_model("first_lit_d0");

    // Load 12AF / dp on digit 2; capture edge still shows the old shadow
    load = 1'b1; din = 16'h12AF; dp = 4'b0100;
    step(); chk_model("pre_load_old");
    load = 1'b0;
    exp_seg = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    for (int i = 0; i < 17; i++) begin
      step(); chk_model("scan_12af");
    end

    // Mid-slot load of zero
    step(); chk_model("mid_pre0");
    step(); chk_model("mid_pre1");
    load = 1'b1; din = 16'h0000; dp = 4'b0000;
    step(); chk_model("mid_load_old");
    load = 1'b0;
    set_zero_table();
    for (int i = 0; i < 17; i++) begin
      step(); chk_model("scan_zero");
    end

    // Display disable; scan keeps running underneath
    load = 1'b1; din = 16'h12AF; dp = 4'b0100;
    step(); chk_model("reload_old");
    load = 1'b0;
    exp_seg = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); chk("en_off", 8'hFF, 4'b1111);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); chk_model("en_resume");
    end

    // Run to a lit cycle of digit 2, then reset asynchronously
    begin
      int guard;
      guard = 0;
      while (!(((cyc - 1) % Prescale) == 2 && (((cyc - 1) / Prescale) % Digits) == 2)
             && guard < 20) begin
        step();
        guard++;
      end
      checks++;
      assert (guard < 20)
      else begin
        failures++;
        $error("FAIL seek_digit2 guard=%0d want below 20", guard);
      end
    end
    chk_model("at_digit2");
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_reset", 8'hFF, 4'b1111);
    @(negedge clk);
    chk("reset_held", 8'hFF, 4'b1111);
    n_rst = 1'b1;
    cyc   = 0;
    set_zero_table();
    for (int i = 0; i < 8; i++) begin
      step(); chk_model("restart");
    end

`ifdef SEG7_LZB_EN
    load = 1'b1; din = 16'h0070; dp = 4'b0000;
    step(); chk_model("lzb_load_old");
    load = 1'b0;
    exp_seg = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      step(); chk_model("lzb_0070");
    end
    load = 1'b1; din = 16'h0000; dp = 4'b0000;
    step(); chk_model("lzb_load2_old");
    load = 1'b0;
    set_zero_table();
    for (int i = 0; i < 16; i++) begin
      step(); chk_model("lzb_0000");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
